allpass_coef_loader: RTL and testbench
======================================

// Module: allpass_coef_loader
// PURPOSE
//  Upstream companion of the allpass filter. Accepts the N filter coefficients
//  as a serial valid/ready stream and holds them in shadow registers. It then
//  drives the filter's packed coefficient bus c in one atomic update, taken on
//  a sample tick. The filter therefore never computes a sample with a mix of
//  old and new coefficients.
// PARAMETERS
//  WIDTH   16  coefficient width in bits (signed, same format as the filter)
//  N       5   number of coefficients (same N as the filter), N >= 2
//  C_INIT  0   packed WIDTH*N reset value of c_out
// PORTS
//  clk      in   1          clock, shared with the filter
//  rst_n    in   1          asynchronous, active-low reset
//  s_valid  in   1          coefficient word valid
//  s_ready  out  1          loader can accept a word
//  s_data   in   WIDTH      signed coefficient word
//  s_last   in   1          marks the final word of a coefficient set
//  tick     in   1          sample strobe: commits are allowed only on this cycle
//  abort    in   1          drop the pending or partial set
//  c_out    out  WIDTH*N    packed coefficients to the filter's c input
//  c_upd    out  1          one-cycle pulse; high in the first cycle c_out holds a new set
//  busy     out  1          high in LOAD and ARMED
//  err      out  1          one-cycle pulse on a malformed set
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - c_out=C_INIT, c_upd=0, err=0, state=IDLE, idx=0, shadow=0.
//   - s_ready=1 out of reset.
//  Transfer rule:
//   - A word transfers on a posedge where s_valid and s_ready are both 1.
//   - The k-th word of a set (k=0..N-1) is written to shadow[k].
//   - Lane mapping on commit: c_out[WIDTH*(k+1)-1:WIDTH*k] = shadow[k].
//  States:
//   - IDLE: s_ready=1, busy=0. A transfer with idx 0 goes to LOAD, or to
//     ARMED when N==1 (not allowed).
//   - LOAD: s_ready=1, busy=1. On each transfer, idx increments.
//   - LOAD, s_last=1 and idx==N-1: go to ARMED.
//   - LOAD, s_last=1 and idx<N-1 (short set): err pulse, shadow discarded,
//     idx=0, go to IDLE.
//   - LOAD, s_last=0 and idx==N-1 (long set): same as short set. The words that
//     follow start a new set.
//   - ARMED: s_ready=0, busy=1. Wait for tick. On the posedge with tick=1:
//     c_out<=shadow, c_upd<=1 on the next cycle, idx=0, go to IDLE.
//     s_ready=1 from the following cycle.
//  Commit latency: c_out changes on the first tick edge after the last word,
//   at the earliest 1 cycle after the s_last transfer.
//  tick in IDLE or LOAD: no effect. c_out is only written in ARMED.
//  abort=1 in any state: go to IDLE, idx=0, no err. c_out is unchanged.
//  Priority in ARMED: abort+tick in the same cycle means abort wins, no commit.
//  abort during a transfer cycle: the word is accepted but then discarded.
//  Reset mid-set: everything returns to reset values, including c_out=C_INIT.
//  Arithmetic: none. Words pass bit-exact; no saturation or sign handling.
//  err and c_upd are registered outputs. Every other output comes directly
//   from registers or from state.
// TESTING
//  1. Reset: rst_n=0 then released -> c_out=C_INIT, s_ready=1, busy=0,
//     c_upd=0, err=0.
//  2. Load words 1,2,3,4,5 (last on 5), then tick 3 cycles later.
//     -> c_out=={16'd5,16'd4,16'd3,16'd2,16'd1}.
//     -> c_upd high exactly 1 cycle; s_ready=0 until then.
//  3. Short set: 3 words with last on the 3rd -> err pulse 1 cycle.
//     c_out unchanged, busy=0 next cycle.
//  4. Long set: 5 words without last, then a full valid set and a tick.
//     -> err once; the second set is committed correctly.
//  5. In ARMED, abort and tick asserted together -> no commit, no c_upd.
//     s_ready=1 next cycle.
//  6. rst_n asserted while ARMED -> c_out=C_INIT immediately (async).
//     No commit after release.

Source files
------------

// File: rtl/allpass_coef_loader_if.sv
// Serial coefficient stream between a coefficient source and allpass_coef_loader.
// The master drives valid/data/last. The slave returns ready.
interface allpass_coef_loader_if #(
    parameter int WIDTH = 16
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             last;

    modport master (output valid, output data, output last, input  ready);
    modport slave  (input  valid, input  data, input  last, output ready);
endinterface

// File: rtl/allpass_coef_loader.sv
// Shadow-buffers a serial coefficient set and commits it to the filter's packed
// c bus atomically on a sample tick, so the filter never sees a mixed set.
//
// state | meaning
// IDLE  | no set in progress, waiting for the first word
// LOAD  | collecting words into shadow, idx = next slot
// ARMED | full set held, stream stalled, waiting for tick to commit
module allpass_coef_loader #(
    parameter int                    WIDTH  = 16,
    parameter int                    N      = 5,
    parameter logic [WIDTH*N-1:0]    C_INIT = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    allpass_coef_loader_if.slave     s,
    input  logic                     tick,
    input  logic                     abort,
    output logic [WIDTH*N-1:0]       c_out,
    output logic                     c_upd,
    output logic                     busy,
    output logic                     err
);
    localparam int              IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]   LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] shadow [N];
    logic             xfer;

    assign s.ready = (state != ARMED);
    assign busy    = (state != IDLE);
    assign xfer    = s.valid && s.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            c_out <= C_INIT;
            c_upd <= 1'b0;
            err   <= 1'b0;
            for (int k = 0; k < N; k++) shadow[k] <= '0;
        end else begin
            c_upd <= 1'b0;
            err   <= 1'b0;
            // abort outranks everything, including a tick in ARMED
            if (abort) begin
                state <= IDLE;
                idx   <= '0;
            end else begin
                case (state)
                    IDLE, LOAD: begin
                        if (xfer) begin
                            shadow[idx] <= s.data;
                            if (s.last && idx == LAST_IDX) begin
                                state <= ARMED;
                                idx   <= '0;
                            end else if (s.last || idx == LAST_IDX) begin
                                // short or long set: drop it, next word starts afresh
                                err   <= 1'b1;
                                state <= IDLE;
                                idx   <= '0;
                            end else begin
                                state <= LOAD;
                                idx   <= idx + IW'(1);
                            end
                        end
                    end
                    ARMED: begin
                        if (tick) begin
                            for (int k = 0; k < N; k++) c_out[WIDTH*k +: WIDTH] <= shadow[k];
                            c_upd <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        idx   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_allpass_coef_loader.sv
// Bench for allpass_coef_loader: directed scenarios plus random traffic, all
// checked against a queue-based model of the coefficient set protocol.
module tb_allpass_coef_loader;
    localparam int              W      = 16;
    localparam int              N      = 5;
    localparam logic [W*N-1:0]  C_INIT = 80'h1111_2222_3333_4444_5555;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           tick = 1'b0;
    logic           abort = 1'b0;
    logic [W*N-1:0] c_out;
    logic           c_upd, busy, err;

    allpass_coef_loader_if #(.WIDTH(W)) bus ();

    allpass_coef_loader #(.WIDTH(W), .N(N), .C_INIT(C_INIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (bus.slave),
        .tick  (tick),
        .abort (abort),
        .c_out (c_out),
        .c_upd (c_upd),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Model: words of the set in progress, the armed set, and the committed bus
    logic [W-1:0]   m_q [$];
    logic [W*N-1:0] m_pend;
    logic [W*N-1:0] m_c;
    bit             m_armed, m_upd, m_err;

    task automatic model_reset();
        m_q.delete();
        m_pend  = '0;
        m_c     = C_INIT;
        m_armed = 1'b0;
        m_upd   = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [W-1:0] d, input bit l,
                              input bit t, input bit a);
        m_upd = 1'b0;
        m_err = 1'b0;
        if (a) begin
            m_q.delete();
            m_armed = 1'b0;
        end else if (m_armed) begin
            if (t) begin
                m_c     = m_pend;
                m_upd   = 1'b1;
                m_armed = 1'b0;
            end
        end else if (v) begin
            m_q.push_back(d);
            if (l && m_q.size() == N) begin
                for (int k = 0; k < N; k++) m_pend[W*k +: W] = m_q[k];
                m_armed = 1'b1;
                m_q.delete();
            end else if (l || m_q.size() == N) begin
                m_err = 1'b1;
                m_q.delete();
            end
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, "_s_ready"}, 128'(bus.ready), 128'(!m_armed));
        chk({ph, "_busy"},    128'(busy),      128'(m_armed || m_q.size() != 0));
        chk({ph, "_c_out"},   128'(c_out),     128'(m_c));
        chk({ph, "_c_upd"},   128'(c_upd),     128'(m_upd));
        chk({ph, "_err"},     128'(err),       128'(m_err));
    endtask

    task automatic cyc(input string ph, input bit v, input logic [W-1:0] d, input bit l,
                       input bit t, input bit a);
        @(negedge clk);
        bus.valid = v;
        bus.data  = d;
        bus.last  = l;
        tick      = t;
        abort     = a;
        @(posedge clk);
        model_step(v, d, l, t, a);
        #1;
        check_all(ph);
    endtask

    task automatic idle(input string ph);
        cyc(ph, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_set(input string ph, input logic [W-1:0] base);
        for (int k = 0; k < N; k++)
            cyc(ph, 1'b1, base + W'(k), (k == N - 1), 1'b0, 1'b0);
    endtask

    initial begin
        bus.valid = 1'b0;
        bus.data  = '0;
        bus.last  = 1'b0;
        model_reset();

        // 1. reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_c_out",   128'(c_out),     128'(C_INIT));
        chk("rst_s_ready", 128'(bus.ready), 128'(1));
        chk("rst_busy",    128'(busy),      128'(0));
        chk("rst_c_upd",   128'(c_upd),     128'(0));
        chk("rst_err",     128'(err),       128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        idle("rel");

        // 2. full set, tick on the third cycle after the last word
        load_set("t2", W'(1));
        idle("t2w");
        idle("t2w");
        chk("t2_armed_ready", 128'(bus.ready), 128'(0));
        cyc("t2t", 1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("t2_c_out", 128'(c_out), 128'({16'd5, 16'd4, 16'd3, 16'd2, 16'd1}));
        chk("t2_c_upd", 128'(c_upd), 128'(1));
        idle("t2p");
        chk("t2_c_upd_once", 128'(c_upd), 128'(0));

        // 3. short set
        cyc("t3", 1'b1, 16'h00aa, 1'b0, 1'b0, 1'b0);
        cyc("t3", 1'b1, 16'h00bb, 1'b0, 1'b1, 1'b0);
        cyc("t3", 1'b1, 16'h00cc, 1'b1, 1'b0, 1'b0);
        chk("t3_err", 128'(err), 128'(1));
        chk("t3_busy", 128'(busy), 128'(0));
        idle("t3p");

        // 4. long set, then a good set committed
        for (int k = 0; k < N; k++) cyc("t4l", 1'b1, W'(16'h0100 + k), 1'b0, 1'b0, 1'b0);
        chk("t4_err", 128'(err), 128'(1));
        load_set("t4", 16'h8000);
        cyc("t4t", 1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("t4_c_out", 128'(c_out), 128'({16'h8004, 16'h8003, 16'h8002, 16'h8001, 16'h8000}));

        // 5. abort beats tick in ARMED
        load_set("t5", 16'h7ff0);
        cyc("t5a", 1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("t5_no_upd", 128'(c_upd), 128'(0));
        chk("t5_ready",  128'(bus.ready), 128'(1));
        cyc("t5t", 1'b0, '0, 1'b0, 1'b1, 1'b0);

        // 6. async reset while ARMED
        load_set("t6", 16'hf00d);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_c_out_async", 128'(c_out), 128'(C_INIT));
        chk("t6_ready_async", 128'(bus.ready), 128'(1));
        chk("t6_busy_async",  128'(busy), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc("t6t", 1'b0, '0, 1'b0, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            bit v, l, t, a;
            v = ($urandom_range(0, 3) != 0);
            l = (m_q.size() == N - 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 39) == 0);
            cyc("rnd", v, W'($urandom), l, t, a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
